bram128_stream_ctrl: RTL

BRAM128_STREAM_CTRL -- requirements
Module: bram128_stream_ctrl

---
 rtl/bram128_stream_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/bram128_stream_ctrl.sv
// rtl/bram128_stream_ctrl.sv - streams 32-bit coefficients into and out of a DW-wide BRAM
//
// Load:  start_load packs ss_* words four to a line and writes each line once.
// Drain: start_drain reads each line back and emits its lanes on sm_*, lane 0 first.
// Ports: CLK/RST (async active-high), start_load/start_drain pulses, busy/done/err status,
//        ss_* input stream, sm_* output stream, bram_* single-port BRAM master.
module bram128_stream_ctrl #(
  parameter int DW = 128,
  parameter int WL = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start_load,
  input  logic          start_drain,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          ss_tvalid,
  output logic          ss_tready,
  input  logic          ss_tlast,
  input  logic [31:0]   ss_tdata,
  output logic          sm_tvalid,
  input  logic          sm_tready,
  output logic          sm_tlast,
  output logic [31:0]   sm_tdata,
  output logic          bram_EN,
  output logic [3:0]    bram_WE,
  output logic [12:0]   bram_A,
  output logic [DW-1:0] bram_Di,
  input  logic [DW-1:0] bram_Do
);

  localparam int LANES  = DW / 32;
  localparam int LANE_W = $clog2(LANES);
  localparam int LINE_W = $clog2(WL);

  typedef enum logic [2:0] {
    IDLE, LD_COLLECT, LD_WRITE, RD_ADDR, RD_CAP, RD_OUT
  } state_t;

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [DW-1:0]       pack_q, pack_d;
  logic [DW-1:0]       buf_q, buf_d;
  logic                err_q, err_d;
  logic                last_q, last_d;   // tlast was accepted into the pending line
  logic                done_q, done_d;

  logic last_line, last_lane;
  logic [12:0] line_addr;

  assign last_line = (line_q == LINE_W'(WL - 1));
  assign last_lane = (lane_q == LANE_W'(LANES - 1));
  assign line_addr = 13'({line_q, 2'b00});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      line_q  <= '0;
      lane_q  <= '0;
      pack_q  <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      lane_q  <= lane_d;
      pack_q  <= pack_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    lane_d    = lane_q;
    pack_d    = pack_q;
    buf_d     = buf_q;
    err_d     = err_q;
    last_d    = last_q;
    done_d    = 1'b0;
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    sm_tlast  = 1'b0;
    sm_tdata  = '0;
    bram_EN   = 1'b0;
    bram_WE   = 4'h0;
    bram_A    = '0;
    bram_Di   = '0;

    case (state_q)
      IDLE: begin
        if (start_load) begin
          state_d = LD_COLLECT;
          line_d  = '0;
          lane_d  = '0;
          pack_d  = '0;
          err_d   = 1'b0;
          last_d  = 1'b0;
        end else if (start_drain) begin
          state_d = RD_ADDR;
          line_d  = '0;
          lane_d  = '0;
        end
      end

      LD_COLLECT: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          pack_d[32*lane_q +: 32] = ss_tdata;
          lane_d = lane_q + 1'b1;
          last_d = ss_tlast;
          // tlast must coincide exactly with the final word of the final line
          if (ss_tlast != (last_line && last_lane)) err_d = 1'b1;
          if (last_lane || ss_tlast) state_d = LD_WRITE;
        end
      end

      LD_WRITE: begin
        bram_EN = 1'b1;
        bram_WE = 4'hF;
        bram_A  = line_addr;
        bram_Di = pack_q;
        line_d  = line_q + 1'b1;
        lane_d  = '0;
        pack_d  = '0;
        if (last_line || last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = LD_COLLECT;
        end
      end

      RD_ADDR: begin
        bram_EN = 1'b1;
        bram_A  = line_addr;
        state_d = RD_CAP;
      end

      RD_CAP: begin
        // read data is valid now, one cycle after the address, with EN still high
        bram_EN = 1'b1;
        bram_A  = line_addr;
        buf_d   = bram_Do;
        lane_d  = '0;
        state_d = RD_OUT;
      end

      RD_OUT: begin
        sm_tvalid = 1'b1;
        sm_tdata  = buf_q[32*lane_q +: 32];
        sm_tlast  = last_line && last_lane;
        if (sm_tready) begin
          lane_d = lane_q + 1'b1;
          if (last_lane) begin
            line_d = line_q + 1'b1;
            if (last_line) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = RD_ADDR;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule
